// File: rtl/pong_match_ctrl.sv
// Match controller for pong: free-running game-tick strobe, serve/rally/point FSM,
// and per-player BCD scores with a binary shadow used for the win test.
module pong_match_ctrl #(
  parameter int unsigned TICK_DIV    = 2000000,
  parameter int unsigned SERVE_TICKS = 50,
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned WIN_BY_TWO  = 1,
  parameter int unsigned DIGITS      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  miss_left,
  input  logic                  miss_right,
  output logic                  tick,
  output logic                  ball_run,
  output logic                  ball_reset,
  output logic                  serve_dir,
  output logic [4*DIGITS-1:0]   score_left,
  output logic [4*DIGITS-1:0]   score_right,
  output logic [1:0]            winner,
  output logic [2:0]            state
);

  localparam int unsigned TW   = $clog2(TICK_DIV);
  localparam int unsigned SCW  = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int unsigned SMAX = 10**DIGITS - 1;
  localparam int unsigned SW   = $clog2(SMAX + 1);
  localparam int unsigned BW   = 4*DIGITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    RALLY  = 3'd2,
    PAUSED = 3'd3,
    POINT  = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_cnt;
  logic [SCW-1:0]   serve_cnt;
  logic             start_q;
  logic             start_rise;
  logic [SW-1:0]    bin_l, bin_r;
  logic             load_serve, dec_serve, inc_l, inc_r, clr_scores;
  logic             dir_d;
  logic [1:0]       winner_d;
  logic             win;
  logic [SW:0]      me, other;

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_rise = start & ~start_q;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (tick_cnt == TW'(TICK_DIV - 1));
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
    end
  end

  // serve_dir was set toward the conceding player on the miss, so in POINT
  // serve_dir=1 identifies the left player as the one who just scored.
  always_comb begin
    me    = serve_dir ? {1'b0, bin_l} : {1'b0, bin_r};
    other = serve_dir ? {1'b0, bin_r} : {1'b0, bin_l};
    win   = (32'(me) >= WIN_SCORE) &&
            ((WIN_BY_TWO == 0) || (32'(me) >= 32'(other) + 32'd2));
  end

  always_comb begin
    state_d    = state_q;
    load_serve = 1'b0;
    dec_serve  = 1'b0;
    inc_l      = 1'b0;
    inc_r      = 1'b0;
    clr_scores = 1'b0;
    dir_d      = serve_dir;
    winner_d   = winner;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d    = SERVE;
          load_serve = 1'b1;
        end
      end
      SERVE: begin
        if (tick) begin
          if (serve_cnt == '0) state_d   = RALLY;
          else                 dec_serve = 1'b1;
        end
      end
      RALLY: begin
        if (miss_left && miss_right) begin
          state_d    = SERVE;
          load_serve = 1'b1;
        end else if (miss_left) begin
          inc_r   = 1'b1;
          dir_d   = 1'b0;
          state_d = POINT;
        end else if (miss_right) begin
          inc_l   = 1'b1;
          dir_d   = 1'b1;
          state_d = POINT;
        end else if (pause) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (!pause) state_d = RALLY;
      end
      POINT: begin
        if (win) begin
          state_d  = OVER;
          winner_d = serve_dir ? 2'b01 : 2'b10;
        end else begin
          state_d    = SERVE;
          load_serve = 1'b1;
        end
      end
      OVER: begin
        if (start_rise) begin
          clr_scores = 1'b1;
          winner_d   = 2'b00;
          state_d    = SERVE;
          load_serve = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      serve_cnt  <= '0;
      start_q    <= 1'b0;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b1;
      winner     <= 2'b00;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      ball_run   <= (state_d == RALLY);
      ball_reset <= (state_d == SERVE) && (state_q != SERVE);
      serve_dir  <= dir_d;
      winner     <= winner_d;
      if (load_serve)     serve_cnt <= SCW'(SERVE_TICKS - 1);
      else if (dec_serve) serve_cnt <= serve_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_scores) begin
      bin_l       <= '0;
      bin_r       <= '0;
      score_left  <= '0;
      score_right <= '0;
    end else begin
      if (inc_l && (bin_l != SW'(SMAX))) begin
        bin_l      <= bin_l + 1'b1;
        score_left <= bcd_inc(score_left);
      end
      if (inc_r && (bin_r != SW'(SMAX))) begin
        bin_r       <= bin_r + 1'b1;
        score_right <= bcd_inc(score_right);
      end
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios plus randomized rallies,
// checked against an integer score/rule model.
module tb_pong_match_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start_a = 1'b0, pause_a = 1'b0, ml_a = 1'b0, mr_a = 1'b0;
  logic start_b = 1'b0, pause_b = 1'b0, ml_b = 1'b0, mr_b = 1'b0;
  logic tick_a, run_a, rst_a, dir_a, tick_b, run_b, rst_b, dir_b;
  logic [7:0] sl_a, sr_a, sl_b, sr_b;
  logic [1:0] win_a, win_b;
  logic [2:0] st_a, st_b;

  int checks = 0;
  int failures = 0;
  logic sel6 = 1'b0;
  int ml = 0, mr = 0;
  bit sd = 1'b1;
  bit won;

  pong_match_ctrl #(.TICK_DIV(TD), .SERVE_TICKS(ST), .WIN_SCORE(3), .WIN_BY_TWO(1), .DIGITS(2)) dut (
    .clk(clk), .reset(reset), .start(start_a), .pause(pause_a),
    .miss_left(ml_a), .miss_right(mr_a), .tick(tick_a), .ball_run(run_a),
    .ball_reset(rst_a), .serve_dir(dir_a), .score_left(sl_a), .score_right(sr_a),
    .winner(win_a), .state(st_a));

  pong_match_ctrl #(.TICK_DIV(TD), .SERVE_TICKS(ST), .WIN_SCORE(99), .WIN_BY_TWO(0), .DIGITS(2)) dut99 (
    .clk(clk), .reset(reset), .start(start_b), .pause(pause_b),
    .miss_left(ml_b), .miss_right(mr_b), .tick(tick_b), .ball_run(run_b),
    .ball_reset(rst_b), .serve_dir(dir_b), .score_left(sl_b), .score_right(sr_b),
    .winner(win_b), .state(st_b));

  logic o_tick, o_run, o_rst, o_dir;
  logic [7:0] o_sl, o_sr;
  logic [1:0] o_win;
  logic [2:0] o_state;
  always_comb begin
    if (sel6) begin
      o_tick = tick_b; o_run = run_b; o_rst = rst_b; o_dir = dir_b;
      o_sl = sl_b; o_sr = sr_b; o_win = win_b; o_state = st_b;
    end else begin
      o_tick = tick_a; o_run = run_a; o_rst = rst_a; o_dir = dir_a;
      o_sl = sl_a; o_sr = sr_a; o_win = win_a; o_state = st_a;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic st, input logic pa, input logic l, input logic r);
    if (sel6) begin start_b = st; pause_b = pa; ml_b = l; mr_b = r; end
    else begin start_a = st; pause_a = pa; ml_a = l; mr_a = r; end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic bit model_win(input int me, input int oth);
    int ws;
    bit w2;
    ws = sel6 ? 99 : 3;
    w2 = !sel6;
    return (me >= ws) && (!w2 || (me - oth >= 2));
  endfunction

  task automatic check_scores(input string tag);
    chk({tag, "_sl"}, o_sl, to_bcd(ml));
    chk({tag, "_sr"}, o_sr, to_bcd(mr));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_tick"}, o_tick, 0);
    chk({tag, "_run"}, o_run, 0);
    chk({tag, "_brst"}, o_rst, 0);
    chk({tag, "_dir"}, o_dir, 1);
    chk({tag, "_sl"}, o_sl, 0);
    chk({tag, "_sr"}, o_sr, 0);
    chk({tag, "_win"}, o_win, 0);
    chk({tag, "_state"}, o_state, 0);
  endtask

  task automatic wait_state(input logic [2:0] target, input string tag);
    int n = 0;
    while (o_state !== target && n < 300) begin
      step();
      n++;
    end
    chk(tag, o_state, target);
  endtask

  // Called at the first cycle of SERVE; counts the ticks seen before RALLY.
  task automatic serve_phase(input string tag);
    int n = 0;
    int cyc = 0;
    while (o_state === 3'd1 && cyc < 200) begin
      if (o_tick === 1'b1) n++;
      if (cyc == 1) chk({tag, "_brst_low"}, o_rst, 0);
      step();
      cyc++;
    end
    chk({tag, "_to_rally"}, o_state, 2);
    chk({tag, "_ticks"}, n, ST);
    chk({tag, "_run"}, o_run, 1);
  endtask

  task automatic play_point(input bit right, output bit w);
    wait_state(3'd2, "pp_rally");
    repeat ($urandom_range(0, 3)) step();
    if ($urandom_range(0, 4) == 0) begin
      drv(1, 0, 0, 0); step(); drv(0, 0, 0, 0);
      chk("rally_start_ignored", o_state, 2);
    end
    if ($urandom_range(0, 3) == 0) begin
      drv(0, 1, 0, 0); step();
      chk("pp_paused", o_state, 3);
      chk("pp_paused_run", o_run, 0);
      if ($urandom_range(0, 1) == 1) begin
        drv(0, 1, 1, 0); step(); drv(0, 1, 0, 0);
        chk("pp_paused_miss", o_state, 3);
        check_scores("pp_paused_miss");
      end
      drv(0, 0, 0, 0); step();
      chk("pp_resume", o_state, 2);
      chk("pp_resume_run", o_run, 1);
    end
    if (right) drv(0, 0, 1, 0);
    else       drv(0, 0, 0, 1);
    step();
    drv(0, 0, 0, 0);
    if (right) mr = (mr < 99) ? mr + 1 : 99;
    else       ml = (ml < 99) ? ml + 1 : 99;
    sd = !right;
    chk("pp_point", o_state, 4);
    check_scores("pp_point");
    chk("pp_dir", o_dir, sd);
    chk("pp_point_run", o_run, 0);
    w = right ? model_win(mr, ml) : model_win(ml, mr);
    step();
    if (w) begin
      chk("pp_over", o_state, 5);
      chk("pp_winner", o_win, right ? 2 : 1);
    end else begin
      chk("pp_serve", o_state, 1);
      chk("pp_brst", o_rst, 1);
      chk("pp_nowin", o_win, 0);
    end
  endtask

  initial begin
    repeat (3) step();
    reset_vals("rst0");
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("tick_c%0d", k), o_tick, 32'(k % TD == 0));
    end
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("tick_r_c%0d", k), o_tick, 32'(k % TD == 0));
    end
    reset = 1'b1; step();
    chk("tick_in_reset", o_tick, 0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tick_after_c%0d", k), o_tick, 32'(k % TD == 0));
    end

    // first serve, start held high through SERVE
    drv(1, 0, 0, 0); step();
    chk("s2_state", o_state, 1);
    chk("s2_brst", o_rst, 1);
    chk("s2_run", o_run, 0);
    serve_phase("s2");
    drv(0, 0, 0, 0);

    play_point(1, won);
    chk("s3_sr", o_sr, 8'h01);
    drv(0, 0, 0, 1); step(); drv(0, 0, 0, 0);
    chk("s3_serve_miss_state", o_state, 1);
    check_scores("s3_serve_miss");

    play_point(0, won);
    play_point(0, won);
    play_point(1, won);
    play_point(1, won);
    chk("s4_23_sr", o_sr, 8'h03);
    play_point(1, won);
    chk("s4_sr", o_sr, 8'h04);
    chk("s4_sl", o_sl, 8'h02);
    chk("s4_winner", o_win, 2'b10);
    drv(0, 0, 0, 1); step(); drv(0, 0, 0, 0);
    chk("s4_over_hold", o_state, 5);
    check_scores("s4_over_hold");
    drv(1, 0, 0, 0); step(); drv(0, 0, 0, 0);
    ml = 0; mr = 0;
    chk("s4_restart", o_state, 1);
    check_scores("s4_restart");
    chk("s4_restart_win", o_win, 0);
    chk("s4_restart_dir", o_dir, 0);
    chk("s4_restart_brst", o_rst, 1);
    serve_phase("s4");

    drv(0, 1, 0, 0); step();
    chk("s5_paused", o_state, 3);
    chk("s5_paused_run", o_run, 0);
    drv(0, 1, 1, 0); step(); drv(0, 1, 0, 0);
    chk("s5_paused_miss", o_state, 3);
    check_scores("s5_paused_miss");
    drv(0, 0, 0, 0); step();
    chk("s5_resume", o_state, 2);
    chk("s5_resume_run", o_run, 1);
    drv(0, 1, 0, 1); step(); drv(0, 1, 0, 0);
    ml = ml + 1; sd = 1'b1;
    chk("s5_pause_miss_point", o_state, 4);
    check_scores("s5_pause_miss");
    drv(0, 0, 0, 0); step();
    chk("s5_serve", o_state, 1);
    serve_phase("s5a");
    drv(0, 0, 1, 1); step(); drv(0, 0, 0, 0);
    chk("s5_both_state", o_state, 1);
    check_scores("s5_both");
    chk("s5_both_dir", o_dir, sd);
    chk("s5_both_brst", o_rst, 1);
    serve_phase("s5b");

    for (int p = 0; p < 24; p++) begin
      bit rs;
      rs = 1'($urandom_range(0, 1));
      play_point(rs, won);
      if (won) begin
        drv(1, 0, 0, 0); step(); drv(0, 0, 0, 0);
        ml = 0; mr = 0;
        chk("rnd_restart", o_state, 1);
        check_scores("rnd_restart");
        chk("rnd_restart_win", o_win, 0);
        chk("rnd_restart_dir", o_dir, sd);
      end
      serve_phase("rnd");
    end

    reset = 1'b1; step();
    reset_vals("midreset");
    reset = 1'b0;
    ml = 0; mr = 0; sd = 1'b1;

    sel6 = 1'b1;
    step();
    drv(1, 0, 0, 0); step(); drv(0, 0, 0, 0);
    chk("s6_serve", o_state, 1);
    for (int i = 1; i <= 99; i++) begin
      play_point(0, won);
      if (i == 10) chk("s6_ten", o_sl, 8'h10);
    end
    chk("s6_sl99", o_sl, 8'h99);
    chk("s6_winner", o_win, 2'b01);
    chk("s6_over", o_state, 5);
    drv(0, 0, 0, 1); step(); drv(0, 0, 0, 0);
    chk("s6_hold_sl", o_sl, 8'h99);
    chk("s6_hold_state", o_state, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
